// File: rtl/seq_mult_4x4.sv
// ---------------------------------------------------------------------------
// seq_mult_4x4 -- sequential 4x4 unsigned shift-add multiplier
//
// Low-area alternative to the combinational array multiplier. The product is
// built over four clocks. Each clock adds one partial product, and it uses the
// team's mux_8bit to choose between accumulate and hold.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  operation request, sampled only while idle
//   a        in   4  multiplicand (unsigned), sampled with start
//   b        in   4  multiplier (unsigned), sampled with start
//   busy     out  1  high while the four iterations run
//   done     out  1  one-cycle pulse, product is valid
//   product  out  8  result register, holds until the next result or reset
//
// mux_8bit -- 2:1 multiplexer, 8 bits wide
//   in0, in1  in   8  data inputs
//   sel       in   1  0 selects in0, 1 selects in1
//   out       out  8  selected data
// ---------------------------------------------------------------------------

module mux_8bit (
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic       sel,
  output logic [7:0] out
);

  assign out = sel ? in1 : in0;

endmodule

module seq_mult_4x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  mcand;
  logic [3:0]  mplr;
  logic [7:0]  acc;
  logic [1:0]  cnt;
  logic [7:0]  acc_sum;
  logic [7:0]  acc_next;

  // The carry out of bit 7 is dropped. 15*15 = 225 fits, so it is never set.
  assign acc_sum = acc + mcand;

  // The current multiplier LSB selects whether this partial product is added.
  mux_8bit u_acc_mux (
    .in0 (acc),
    .in1 (acc_sum),
    .sel (mplr[0]),
    .out (acc_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers. A reset discards any in-flight operation and clears
  // the held product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= 8'd0;
      mplr    <= 4'd0;
      acc     <= 8'd0;
      cnt     <= 2'd0;
      product <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= {4'b0000, a};
            mplr  <= b;
            acc   <= 8'd0;
            cnt   <= 2'd0;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mcand <= {mcand[6:0], 1'b0};
          mplr  <= {1'b0, mplr[3:1]};
          cnt   <= cnt + 2'd1;
          // The fourth iteration writes the product directly from the adder
          // path. This makes the result valid in the same cycle as done.
          if (cnt == 2'd3) begin
            product <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic. Outputs are decoded from the state alone, so a start
  // raised during CALC or DONE has no effect.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == 2'd3) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_mult_4x4.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_4x4 -- directed testbench for seq_mult_4x4
//
// Checks the reset state and the E0..E5 timing of busy, done and product.
// Also covers zero operands, back-to-back issue with the previous product
// held, ignored start pulses, and a mid-operation reset. It ends with a
// back-to-back sweep of all 256 operand pairs.
// ---------------------------------------------------------------------------

module tb_seq_mult_4x4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int         checks;
  int         errors;
  logic [7:0] held_product;

  seq_mult_4x4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Runs one operation from the start edge E0 through E5 and checks each
  // cycle. With noisy set, a and b are changed after E0, and start is pulsed
  // during CALC and during DONE. The DUT must ignore all of these.
  task automatic applyStimulus(input logic [3:0] a_in, input logic [3:0] b_in,
                               input logic [7:0] expected, input logic noisy,
                               input string tag);
    @(negedge clk);
    a     = a_in;
    b     = b_in;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (noisy) begin
      a = 4'd1;
      b = 4'd1;
    end
    checkOutput({tag, "_busy_e0"}, {7'd0, busy}, 8'd1);
    checkOutput({tag, "_done_e0"}, {7'd0, done}, 8'd0);
    checkOutput({tag, "_prod_e0"}, product, held_product);
    for (int e = 1; e <= 4; e++) begin
      if (noisy && e == 2) start = 1'b1;
      if (noisy && e == 3) start = 1'b0;
      @(posedge clk);
      #1;
      if (e < 4) begin
        checkOutput({tag, "_busy_calc"}, {7'd0, busy}, 8'd1);
        checkOutput({tag, "_done_calc"}, {7'd0, done}, 8'd0);
        checkOutput({tag, "_prod_held"}, product, held_product);
      end else begin
        checkOutput({tag, "_busy_e4"}, {7'd0, busy}, 8'd0);
        checkOutput({tag, "_done_e4"}, {7'd0, done}, 8'd1);
        checkOutput({tag, "_prod_e4"}, product, expected);
      end
    end
    if (noisy) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_done_e5"}, {7'd0, done}, 8'd0);
    checkOutput({tag, "_busy_e5"}, {7'd0, busy}, 8'd0);
    checkOutput({tag, "_prod_e5"}, product, expected);
    held_product = expected;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    held_product = 8'd0;
    start        = 1'b0;
    a            = 4'd0;
    b            = 4'd0;
    rst_n        = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_done", {7'd0, done}, 8'd0);
    checkOutput("rst_prod", product, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Largest operands
    applyStimulus(4'd15, 4'd15, 8'hE1, 1'b0, "max");

    // Zero operands take the full latency, with no early exit
    applyStimulus(4'd0, 4'd9, 8'd0, 1'b0, "zero_a");
    applyStimulus(4'd9, 4'd0, 8'd0, 1'b0, "zero_b");

    // Back-to-back: the second start is sampled in the cycle after done
    applyStimulus(4'd7, 4'd6, 8'd42, 1'b0, "b2b_first");
    applyStimulus(4'd3, 4'd5, 8'd15, 1'b0, "b2b_second");

    // Extra start pulses during CALC and DONE are ignored
    applyStimulus(4'd4, 4'd4, 8'd16, 1'b1, "ignore");
    repeat (6) begin
      @(posedge clk);
      #1;
      checkOutput("ignore_no_busy", {7'd0, busy}, 8'd0);
      checkOutput("ignore_no_done", {7'd0, done}, 8'd0);
    end

    // Reset after two iterations clears everything at once
    @(negedge clk);
    a     = 4'd12;
    b     = 4'd11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("midrst_busy_before", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {7'd0, busy}, 8'd0);
    checkOutput("midrst_done", {7'd0, done}, 8'd0);
    checkOutput("midrst_prod", product, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    held_product = 8'd0;
    repeat (6) begin
      @(posedge clk);
      #1;
      checkOutput("midrst_no_done", {7'd0, done}, 8'd0);
      checkOutput("midrst_no_busy", {7'd0, busy}, 8'd0);
    end
    applyStimulus(4'd2, 4'd3, 8'd6, 1'b0, "after_rst");

    // Exhaustive sweep, issued back-to-back
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [3:0] ai;
        logic [3:0] bj;
        logic [7:0] pij;
        ai  = 4'(i);
        bj  = 4'(j);
        pij = 8'(i * j);
        applyStimulus(ai, bj, pij, 1'b0, "sweep");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
